uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   UART receiver with buffering. Deserialises 8N1 frames from the RXD line into a first-word-fall-through FIFO.
//   Feeds the RX escape stage through the DATA_REC/RX_EMPTY/READ handshake.
//   Sits between the board RXD pin and the escape/TAP path of the debug UART.
// PARAMETERS
//   CLKS_PER_BIT  868  CLK_I cycles per bit (100 MHz / 115200); must be >= 4
//   FIFO_DEPTH    8    FIFO entries; power of 2, >= 2
// PORTS
//   CLK_I         in   1  single clock; all logic on posedge
//   RST_NI        in   1  asynchronous, active-low reset
//   RXD_I         in   1  serial input, idle high; asynchronous to CLK_I
//   READ_I        in   1  pop head entry; ignored while RX_EMPTY_O=1
//   DATA_REC_O    out  8  FIFO head byte; 0 while RX_EMPTY_O=1
//   RX_EMPTY_O    out  1  FIFO empty
//   RX_FULL_O     out  1  FIFO holds FIFO_DEPTH entries
//   FRAME_ERR_O   out  1  1-cycle pulse: stop bit sampled low
//   OVERRUN_O     out  1  1-cycle pulse: byte dropped because FIFO full
// BEHAVIOUR
//   Reset (RST_NI=0, async, any state): FSM->st_idle; counters, pointers, count cleared; sync FFs set to 1.
//     Outputs: DATA_REC_O=0, RX_EMPTY_O=1, RX_FULL_O=0, FRAME_ERR_O=0, OVERRUN_O=0. Partial frame discarded.
//   RXD_I passes through a 2-FF synchroniser; the FSM uses only the synchronised value rxd_s.
//   FSM states:
//     st_idle: on rxd_s=0 -> st_start, bit counter cleared.
//     st_start: count CLKS_PER_BIT/2 cycles (integer division) to bit centre.
//       rxd_s=0 at centre -> st_data, counter cleared.
//       rxd_s=1 at centre -> st_idle (glitch rejected, nothing stored).
//     st_data: sample rxd_s every CLKS_PER_BIT cycles into the shift register, LSB first.
//       After 8 samples -> st_stop.
//     st_stop: sample after CLKS_PER_BIT cycles, then -> st_idle in the same cycle, so a start edge
//       on the following cycle is caught (back-to-back frames need no extra idle).
//       rxd_s=1: push byte. If FIFO full, byte dropped and OVERRUN_O pulses instead.
//       rxd_s=0: byte dropped, FRAME_ERR_O pulses; no push.
//   Latency: pushed byte visible on DATA_REC_O with RX_EMPTY_O=0 in the cycle after the stop-bit sample cycle.
//   FIFO:
//     count is 0..FIFO_DEPTH; RX_EMPTY_O=(count==0); RX_FULL_O=(count==FIFO_DEPTH); both registered.
//     Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//     DATA_REC_O = mem[rd_ptr] when not empty (FWFT, combinational from the registered pointer), else 0.
//     Pop on READ_I=1 and !empty; head advances the next cycle.
//   Simultaneous events:
//     push + pop, not empty, not full: both happen, count unchanged.
//     push + pop, empty: pop ignored, push stored.
//     push + pop, full: full is evaluated on the current count, so the push is dropped (OVERRUN_O) and the pop happens.
//   FRAME_ERR_O and OVERRUN_O are never high together.
// TESTING (CLKS_PER_BIT=8, FIFO_DEPTH=8)
//   Frame 0xA5 -> RX_EMPTY_O=0, DATA_REC_O=0xA5 one cycle after stop sample; READ_I 1 cycle -> RX_EMPTY_O=1.
//   RXD low for 2 cycles, then high -> no push, no error pulse, FSM back in st_idle.
//   Frame 0x3C with stop bit=0 -> FRAME_ERR_O one pulse, RX_EMPTY_O stays 1.
//   Bytes 0x00..0x08 sent, no reads -> RX_FULL_O after 8th; OVERRUN_O on 9th; read-out 0x00..0x07 in order.
//   Back-to-back 0xB1,0x42 with zero idle, READ_I held high -> both popped in order.
//   RST_NI low mid-frame -> all outputs at reset values at once; next frame 0x55 received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver that deserialises RXD_I into a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       RXD_I,
    input  logic       READ_I,
    output logic [7:0] DATA_REC_O,
    output logic       RX_EMPTY_O,
    output logic       RX_FULL_O,
    output logic       FRAME_ERR_O,
    output logic       OVERRUN_O
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {st_idle, st_start, st_data, st_stop} state_t;
    state_t state, state_nx;
    logic rxd_meta, rxd_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic at_half, at_end, data_smp, stop_smp, push_req, push, pop;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_nx;
    always_ff @(posedge CLK_I or negedge RST_NI)
        if (!RST_NI) {rxd_meta, rxd_s} <= 2'b11;
        else {rxd_meta, rxd_s} <= {RXD_I, rxd_meta};
    always_ff @(posedge CLK_I or negedge RST_NI)
        if (!RST_NI) state <= st_idle;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            st_idle:  if (!rxd_s) state_nx = st_start;
            st_start: if (at_half) state_nx = rxd_s ? st_idle : st_data;
            st_data:  if (data_smp && bit_cnt == 3'd7) state_nx = st_stop;
            st_stop:  if (stop_smp) state_nx = st_idle;
            default:  state_nx = st_idle;
        endcase
    end
    always_comb begin
        at_half  = state == st_start && clk_cnt == HALF_END;
        at_end   = clk_cnt == BIT_END;
        data_smp = state == st_data && at_end;
        stop_smp = state == st_stop && at_end;
    end
    always_ff @(posedge CLK_I or negedge RST_NI)
        if (!RST_NI) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            clk_cnt <= (state == st_idle || at_half || at_end) ? '0 : clk_cnt + CW'(1);
            bit_cnt <= state == st_idle ? 3'd0 : bit_cnt + 3'(data_smp);
            if (data_smp) shift <= {rxd_s, shift[7:1]};
        end
    // Full is judged on the current count, so a push colliding with a pop while full is still dropped.
    always_comb begin
        push_req = stop_smp && rxd_s;
        push     = push_req && !RX_FULL_O;
        pop      = READ_I && !RX_EMPTY_O;
        count_nx = count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
    always_ff @(posedge CLK_I)
        if (push) mem[wr_ptr] <= shift;
    always_ff @(posedge CLK_I or negedge RST_NI)
        if (!RST_NI) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            RX_EMPTY_O  <= 1'b1;
            RX_FULL_O   <= 1'b0;
            FRAME_ERR_O <= 1'b0;
            OVERRUN_O   <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr + AW'(pop);
            count       <= count_nx;
            RX_EMPTY_O  <= count_nx == '0;
            RX_FULL_O   <= count_nx == DEPTH_C;
            FRAME_ERR_O <= stop_smp && !rxd_s;
            OVERRUN_O   <= push_req && RX_FULL_O;
        end
    assign DATA_REC_O = RX_EMPTY_O ? 8'h00 : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a queue-based receive model
module tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DEPTH = 8;
    logic clk = 0, rst_n = 0, rxd = 1, rd = 0;
    logic [7:0] data;
    logic empty, full, fe, ov;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, exp_fe = 0, exp_ov = 0;
    int ne_cyc = -1, stop_cyc = 0, k;
    logic [7:0] ne_data = 0;
    logic prev_empty = 1;
    logic [7:0] got_q[$], mdl_q[$];
    always #5 clk = ~clk;
    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK_I(clk), .RST_NI(rst_n), .RXD_I(rxd), .READ_I(rd),
        .DATA_REC_O(data), .RX_EMPTY_O(empty), .RX_FULL_O(full),
        .FRAME_ERR_O(fe), .OVERRUN_O(ov)
    );
    always @(negedge clk) begin
        cyc++;
        if (rd && !empty) got_q.push_back(data);
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
        if (fe && ov) both_cnt++;
        if (prev_empty && !empty && ne_cyc < 0) begin
            ne_cyc  = cyc;
            ne_data = data;
        end
        prev_empty = empty;
    end
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // The model decides each frame's fate as its stop bit starts, from the bytes stored minus those popped.
    task automatic send(input logic [7:0] b, input logic stop);
        rxd = 0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        if (!stop) exp_fe++;
        else if (mdl_q.size() - got_q.size() >= DEPTH) exp_ov++;
        else mdl_q.push_back(b);
        stop_cyc = cyc;
        rxd = stop;
        tick(CPB);
        rxd = 1;
        if (!stop) tick(2 * CPB);
    endtask
    task automatic drain();
        rd = 1;
        for (int i = 0; i < 3 * DEPTH && !empty; i++) tick();
        rd = 0;
        check("drain_empty", empty, 1);
    endtask
    task automatic cmp_q(input string tag);
        check({tag, "_len"}, got_q.size(), mdl_q.size());
        for (int i = 0; i < mdl_q.size() && i < got_q.size(); i++) check(tag, got_q[i], mdl_q[i]);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
    initial begin
        tick(3);
        rst_n = 1;
        tick(2);
        check("rst_data", data, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_fe", fe, 0);
        check("rst_ov", ov, 0);
        send(8'hA5, 1);
        tick(2);
        check("a5_latency_ok", ne_cyc - stop_cyc >= 6 && ne_cyc - stop_cyc <= 9, 1);
        check("a5_first_head", ne_data, 8'hA5);
        check("a5_empty", empty, 0);
        check("a5_data", data, 8'hA5);
        rd = 1;
        tick();
        rd = 0;
        check("pop_empty", empty, 1);
        check("pop_data_zero", data, 0);
        cmp_q("a5_q");
        rxd = 0;
        tick(2);
        rxd = 1;
        tick(20);
        check("glitch_empty", empty, 1);
        check("glitch_fe", fe_cnt, 0);
        send(8'h3C, 0);
        tick(4);
        check("ferr_count", fe_cnt, exp_fe);
        check("ferr_empty", empty, 1);
        for (int i = 0; i < 8; i++) send(8'(i), 1);
        tick(2);
        check("fill_full", full, 1);
        check("fill_no_ov", ov_cnt, 0);
        send(8'h08, 1);
        tick(2);
        check("fill_ov", ov_cnt, exp_ov);
        check("fill_still_full", full, 1);
        drain();
        cmp_q("fill_q");
        check("fill_not_full", full, 0);
        rd = 1;
        send(8'hB1, 1);
        send(8'h42, 1);
        tick(12);
        rd = 0;
        cmp_q("b2b_q");
        check("b2b_empty", empty, 1);
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(10, 1);
            for (int j = 0; j < k; j++) send(8'($urandom_range(255, 0)), $urandom_range(4, 0) != 0);
            tick(4);
            check("rand_fe", fe_cnt, exp_fe);
            check("rand_ov", ov_cnt, exp_ov);
            drain();
            cmp_q("rand_q");
        end
        check("never_both", both_cnt, 0);
        send(8'h77, 1);
        tick(2);
        check("pre_rst_empty", empty, 0);
        rxd = 0;
        tick(CPB + 10);
        rst_n = 0;
        #1;
        check("arst_data", data, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_fe", fe, 0);
        check("arst_ov", ov, 0);
        tick(2);
        rst_n = 1;
        rxd = 1;
        got_q.delete();
        mdl_q.delete();
        tick(3 * CPB);
        send(8'h55, 1);
        tick(2);
        check("post_rst_empty", empty, 0);
        check("post_rst_data", data, 8'h55);
        drain();
        cmp_q("post_rst_q");
        check("final_fe", fe_cnt, exp_fe);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
